// File: rtl/camera_cfg_pkg.sv
// Shared definitions for the camera configuration sequencer.
//   - cfg_state_e  : sequencer FSM states
//   - DELAY_MARKER : reg_addr value that turns an entry into a pause
//   - XFER_TIMEOUT : cycles allowed for one I2C write before it counts as failed
//   - ARM_CYCLES   : cycles i2c_start is held low before each attempt
//   - delay_load() : converts a delay-entry value into a wait-timer load value
package camera_cfg_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_PWR_WAIT,
        S_LOAD,
        S_FETCH,
        S_ARM,
        S_XFER,
        S_CHECK,
        S_DELAY,
        S_NEXT,
        S_DONE
    } cfg_state_e;

    localparam logic [15:0] DELAY_MARKER = 16'hFFFF;
    localparam int          XFER_TIMEOUT = 64;
    localparam int          ARM_CYCLES   = 2;
    localparam int          TMR_W        = 16;

    // The timer expires when it reaches zero, so a wait of N cycles loads N-1.
    // value*256 cycles; value 0 still spends the single DELAY cycle.
    function automatic logic [TMR_W-1:0] delay_load(input logic [7:0] value);
        if (value == 8'd0) return '0;
        return {value, 8'h00} - 16'd1;
    endfunction

endpackage

// File: rtl/cfg_wait_timer.sv
// Down-counting wait timer shared by the power-up wait, the transfer
// timeout and delay entries.
//   clk_i      : clock
//   rst_i      : synchronous active-high reset
//   load_i     : load load_val_i (takes priority over counting)
//   load_val_i : cycles-1 to wait
//   count_i    : decrement while non-zero
//   expire_o   : counter is zero
module cfg_wait_timer
    import camera_cfg_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [TMR_W-1:0] load_val_i,
    input  logic             count_i,
    output logic             expire_o
);

    logic [TMR_W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (count_i && cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/camera_cfg_seq.sv
// Camera configuration sequencer. Walks a configuration ROM once for
// camera 1 and once for camera 2, issuing one I2C register write per entry
// through an external write engine, with per-entry retries, a transfer
// timeout and in-table delay entries.
//   clock_i2c  : I2C bit clock, all logic on its rising edge
//   camera_rst : synchronous active-high reset
//   cfg_start  : start pulse (accepted in IDLE/DONE only)
//   lut_index  : ROM address;  lut_data : ROM word, one cycle latency
//   i2c_data   : {DEV_ADDR, reg_addr, value} to the engine
//   i2c_start  : engine run level;  tr_end/ack : engine completion/NACK
//   camera1    : target select (0 = camera 1, 1 = camera 2)
//   busy/cfg_done/cfg_error/err_count : status
module camera_cfg_seq
    import camera_cfg_pkg::*;
#(
    parameter logic [7:0] DEV_ADDR  = 8'h78,
    parameter int         LUT_SIZE  = 256,
    parameter int         MAX_RETRY = 3,
    parameter int         PWR_WAIT  = 400
) (
    input  logic        clock_i2c,
    input  logic        camera_rst,
    input  logic        cfg_start,
    output logic [8:0]  lut_index,
    input  logic [23:0] lut_data,
    output logic [31:0] i2c_data,
    output logic        i2c_start,
    input  logic        tr_end,
    input  logic        ack,
    output logic        camera1,
    output logic        busy,
    output logic        cfg_done,
    output logic        cfg_error,
    output logic [7:0]  err_count
);

    localparam logic [8:0]       LAST_IDX  = 9'(LUT_SIZE - 1);
    localparam logic [TMR_W-1:0] PWR_LOAD  = (PWR_WAIT > 0) ? TMR_W'(PWR_WAIT - 1) : '0;
    localparam logic [TMR_W-1:0] XFER_LOAD = TMR_W'(XFER_TIMEOUT - 1);
    localparam logic [7:0]       RETRY_MAX = 8'(MAX_RETRY);
    localparam logic [1:0]       ARM_LAST  = 2'(ARM_CYCLES - 1);

    cfg_state_e  state_q, state_d;
    logic [8:0]  lut_index_q, lut_index_d;
    logic [31:0] i2c_data_q, i2c_data_d;
    logic        camera1_q, camera1_d;
    logic [7:0]  retry_q, retry_d;
    logic [1:0]  arm_cnt_q, arm_cnt_d;
    logic        timeout_q, timeout_d;
    logic        cfg_error_q, cfg_error_d;
    logic [7:0]  err_count_q, err_count_d;

    logic             tmr_load;
    logic [TMR_W-1:0] tmr_val;
    logic             tmr_count;
    logic             tmr_expire;

    logic idle_like;
    logic is_marker;
    logic xfer_fail;
    logic more_work;

    assign idle_like = (state_q == S_IDLE) || (state_q == S_DONE);
    assign is_marker = (lut_data[23:8] == DELAY_MARKER);
    // A timeout fails the attempt regardless of whatever ack happens to show.
    assign xfer_fail = ack || timeout_q;
    assign more_work = (lut_index_q < LAST_IDX) || !camera1_q;

    cfg_wait_timer u_timer (
        .clk_i      (clock_i2c),
        .rst_i      (camera_rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .count_i    (tmr_count),
        .expire_o   (tmr_expire)
    );

    // State register
    always_ff @(posedge clock_i2c) begin
        if (camera_rst) state_q <= S_IDLE;
        else            state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: if (cfg_start) state_d = S_PWR_WAIT;
            S_PWR_WAIT:     if (tmr_expire) state_d = S_LOAD;
            S_LOAD:         state_d = S_FETCH;
            S_FETCH:        state_d = is_marker ? S_DELAY : S_ARM;
            S_ARM:          if (arm_cnt_q == ARM_LAST) state_d = S_XFER;
            S_XFER:         if (tr_end || tmr_expire) state_d = S_CHECK;
            S_CHECK: begin
                if (!xfer_fail)              state_d = S_NEXT;
                else if (retry_q < RETRY_MAX) state_d = S_ARM;
                else                          state_d = S_NEXT;
            end
            S_DELAY:        if (tmr_expire) state_d = S_NEXT;
            S_NEXT:         state_d = more_work ? S_LOAD : S_DONE;
            default:        state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        i2c_start = (state_q == S_XFER);
        busy      = !idle_like;
        cfg_done  = (state_q == S_DONE);
        tmr_count = (state_q == S_PWR_WAIT) || (state_q == S_XFER) || (state_q == S_DELAY);
    end

    // Datapath next-state and timer control
    always_comb begin
        lut_index_d = lut_index_q;
        i2c_data_d  = i2c_data_q;
        camera1_d   = camera1_q;
        retry_d     = retry_q;
        arm_cnt_d   = '0;
        timeout_d   = timeout_q;
        cfg_error_d = cfg_error_q;
        err_count_d = err_count_q;
        tmr_load    = 1'b0;
        tmr_val     = '0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (cfg_start) begin
                    lut_index_d = '0;
                    camera1_d   = 1'b0;
                    retry_d     = '0;
                    cfg_error_d = 1'b0;
                    err_count_d = '0;
                    tmr_load    = 1'b1;
                    tmr_val     = PWR_LOAD;
                end
            end
            S_FETCH: begin
                i2c_data_d = {DEV_ADDR, lut_data};
                if (is_marker) begin
                    tmr_load = 1'b1;
                    tmr_val  = delay_load(lut_data[7:0]);
                end
            end
            S_ARM: begin
                arm_cnt_d = arm_cnt_q + 2'd1;
                // Arm the timeout so it starts with the first XFER cycle.
                if (arm_cnt_q == ARM_LAST) begin
                    tmr_load  = 1'b1;
                    tmr_val   = XFER_LOAD;
                    timeout_d = 1'b0;
                end
            end
            S_XFER: begin
                if (!tr_end && tmr_expire) timeout_d = 1'b1;
            end
            S_CHECK: begin
                if (xfer_fail) begin
                    if (retry_q < RETRY_MAX) begin
                        retry_d = retry_q + 8'd1;
                    end else begin
                        cfg_error_d = 1'b1;
                        if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
                    end
                end
            end
            S_NEXT: begin
                retry_d = '0;
                if (lut_index_q < LAST_IDX) begin
                    lut_index_d = lut_index_q + 9'd1;
                end else if (!camera1_q) begin
                    camera1_d   = 1'b1;
                    lut_index_d = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock_i2c) begin
        if (camera_rst) begin
            lut_index_q <= '0;
            i2c_data_q  <= '0;
            camera1_q   <= 1'b0;
            retry_q     <= '0;
            arm_cnt_q   <= '0;
            timeout_q   <= 1'b0;
            cfg_error_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            lut_index_q <= lut_index_d;
            i2c_data_q  <= i2c_data_d;
            camera1_q   <= camera1_d;
            retry_q     <= retry_d;
            arm_cnt_q   <= arm_cnt_d;
            timeout_q   <= timeout_d;
            cfg_error_q <= cfg_error_d;
            err_count_q <= err_count_d;
        end
    end

    assign lut_index = lut_index_q;
    assign i2c_data  = i2c_data_q;
    assign camera1   = camera1_q;
    assign cfg_error = cfg_error_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_camera_cfg_seq.sv
module tb_camera_cfg_seq;

    localparam int LUT  = 2;
    localparam int MAXR = 3;
    localparam int PWR  = 20;

    logic        clock_i2c = 1'b0;
    logic        camera_rst = 1'b1;
    logic        cfg_start = 1'b0;
    logic [8:0]  lut_index;
    logic [23:0] lut_data;
    logic [31:0] i2c_data;
    logic        i2c_start;
    logic        tr_end = 1'b0;
    logic        ack = 1'b0;
    logic        camera1, busy, cfg_done, cfg_error;
    logic [7:0]  err_count;

    int checks = 0;
    int errors = 0;

    always #5 clock_i2c = ~clock_i2c;

    camera_cfg_seq #(
        .DEV_ADDR (8'h78),
        .LUT_SIZE (LUT),
        .MAX_RETRY(MAXR),
        .PWR_WAIT (PWR)
    ) dut (
        .clock_i2c(clock_i2c),
        .camera_rst(camera_rst),
        .cfg_start(cfg_start),
        .lut_index(lut_index),
        .lut_data(lut_data),
        .i2c_data(i2c_data),
        .i2c_start(i2c_start),
        .tr_end(tr_end),
        .ack(ack),
        .camera1(camera1),
        .busy(busy),
        .cfg_done(cfg_done),
        .cfg_error(cfg_error),
        .err_count(err_count)
    );

    // Configuration ROM with one cycle read latency
    logic [23:0] rom [LUT];
    always @(posedge clock_i2c) begin
        if (int'(lut_index) < LUT) lut_data <= rom[int'(lut_index)];
        else                       lut_data <= 24'h0;
    end

    // Engine model: NACK plan per (camera, entry, attempt), optional silence
    bit          nack_tab [2][LUT][8];
    bit          no_trend = 1'b0;
    int          att_cnt [2][LUT];
    logic [32:0] log_q [$];
    int          len_q [$];
    int          gap_q [$];
    int          xcyc = 0, lat = 0, gap_cnt = 0;
    bit          cur_nack = 1'b0;

    always @(negedge clock_i2c) begin
        if (i2c_start === 1'b1) begin
            if (xcyc == 0) begin
                int ci, ei;
                if (log_q.size() > 0) gap_q.push_back(gap_cnt);
                gap_cnt = 0;
                log_q.push_back({camera1, i2c_data});
                lat = int'($urandom_range(8, 2));
                ci = int'(camera1);
                ei = int'(lut_index) % LUT;
                cur_nack = nack_tab[ci][ei][att_cnt[ci][ei] % 8];
                att_cnt[ci][ei]++;
            end
            xcyc++;
            if (!no_trend && xcyc == lat) begin
                tr_end = 1'b1;
                ack    = cur_nack;
            end else if (tr_end == 1'b0) begin
                ack = 1'($urandom_range(1, 0));   // noise before completion
            end
        end else begin
            if (xcyc != 0) len_q.push_back(xcyc);
            xcyc   = 0;
            tr_end = 1'b0;
            if (log_q.size() > 0) gap_cnt++;
        end
    end

    // Reference model: the ordered list of writes the sequence must produce
    logic [32:0] exp_q [$];
    int          exp_err;

    task automatic build_model();
        exp_q.delete();
        exp_err = 0;
        for (int c = 0; c < 2; c++) begin
            for (int e = 0; e < LUT; e++) begin
                bit ok;
                if (rom[e][23:8] == 16'hFFFF) continue;
                ok = 1'b0;
                for (int a = 0; a <= MAXR && !ok; a++) begin
                    exp_q.push_back({1'(c), 8'h78, rom[e]});
                    if (!no_trend && !nack_tab[c][e][a]) ok = 1'b1;
                end
                if (!ok) exp_err++;
            end
        end
    endtask

    function automatic int log_diff();
        if (log_q.size() != exp_q.size()) return -2;
        foreach (exp_q[i]) if (log_q[i] !== exp_q[i]) return i;
        return -1;
    endfunction

    task automatic clear_plan();
        no_trend = 1'b0;
        for (int c = 0; c < 2; c++)
            for (int e = 0; e < LUT; e++)
                for (int a = 0; a < 8; a++) nack_tab[c][e][a] = 1'b0;
    endtask

    task automatic start_run();
        log_q.delete(); len_q.delete(); gap_q.delete();
        gap_cnt = 0;
        for (int c = 0; c < 2; c++)
            for (int e = 0; e < LUT; e++) att_cnt[c][e] = 0;
        build_model();
        @(negedge clock_i2c) cfg_start = 1'b1;
        @(negedge clock_i2c) cfg_start = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            if (cfg_done === 1'b1) begin ok = 1'b1; return; end
            @(negedge clock_i2c);
        end
    endtask

    task automatic wait_xfer(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (i2c_start === 1'b1) begin ok = 1'b1; return; end
            @(negedge clock_i2c);
        end
    endtask

    task automatic test_reset();
        rom[0] = 24'h3008_82;
        rom[1] = 24'h1234_56;
        clear_plan();
        camera_rst = 1'b1;
        repeat (3) @(negedge clock_i2c);
        checks++; if ({i2c_start, busy, cfg_done, cfg_error} !== 4'b0) begin errors++;
            $display("FAIL reset_ctl: got %b want 0000", {i2c_start, busy, cfg_done, cfg_error}); end
        checks++; if (i2c_data !== 32'h0) begin errors++;
            $display("FAIL reset_data: got %h want 0", i2c_data); end
        checks++; if ({camera1, lut_index, err_count} !== 18'h0) begin errors++;
            $display("FAIL reset_idx: cam=%b idx=%0d err=%0d want 0", camera1, lut_index, err_count); end
        camera_rst = 1'b0;
        @(negedge clock_i2c);
    endtask

    task automatic test_basic();
        bit ok; int d;
        clear_plan();
        rom[0] = 24'h3008_82;
        rom[1] = {16'($urandom_range(16'hFFFE, 0)), 8'($urandom)};
        if (rom[1] == rom[0]) rom[1] = 24'h1234_56;
        start_run();
        checks++; if ({busy, cfg_done} !== 2'b10) begin errors++;
            $display("FAIL basic_busy: busy/done=%b want 10", {busy, cfg_done}); end
        wait_done(ok);
        checks++; if (!ok) begin errors++; $display("FAIL basic_done: timeout waiting for cfg_done"); end
        d = log_diff();
        checks++; if (d != -1) begin errors++;
            $display("FAIL basic_log: diff=%0d got_n=%0d want_n=%0d", d, log_q.size(), exp_q.size()); end
        checks++; if (log_q.size() < 1 || log_q[0] !== 33'h0_7830_0882) begin errors++;
            $display("FAIL basic_first: got %h want 0_78300882", (log_q.size() > 0) ? log_q[0] : 33'h0); end
        checks++; if ({cfg_error, err_count, busy} !== 10'h0) begin errors++;
            $display("FAIL basic_status: err=%b cnt=%0d busy=%b want 0", cfg_error, err_count, busy); end
        repeat (10) @(negedge clock_i2c);
        checks++; if (cfg_done !== 1'b1) begin errors++;
            $display("FAIL basic_done_hold: got %b want 1", cfg_done); end
    endtask

    task automatic test_retry();
        bit ok; int d, n;
        clear_plan();
        rom[0] = 24'h3008_82; rom[1] = 24'h1234_56;
        nack_tab[0][0][0] = 1'b1;
        nack_tab[0][0][1] = 1'b1;
        start_run();
        wait_done(ok);
        checks++; if (!ok) begin errors++; $display("FAIL retry_done: timeout waiting for cfg_done"); end
        d = log_diff();
        checks++; if (d != -1) begin errors++;
            $display("FAIL retry_log: diff=%0d got_n=%0d want_n=%0d", d, log_q.size(), exp_q.size()); end
        n = 0;
        foreach (log_q[i]) if (log_q[i] === {1'b0, 8'h78, rom[0]}) n++;
        checks++; if (n != 3) begin errors++; $display("FAIL retry_count: got %0d want 3", n); end
        checks++; if ({cfg_error, err_count} !== 9'h0) begin errors++;
            $display("FAIL retry_err: err=%b cnt=%0d want 0", cfg_error, err_count); end
    endtask

    task automatic test_exhaust();
        bit ok; int d;
        clear_plan();
        rom[0] = 24'h3008_82; rom[1] = 24'h1234_56;
        for (int a = 0; a < 8; a++) nack_tab[1][1][a] = 1'b1;
        start_run();
        wait_done(ok);
        checks++; if (!ok) begin errors++; $display("FAIL exhaust_done: timeout waiting for cfg_done"); end
        d = log_diff();
        checks++; if (d != -1 || log_q.size() != 3 + MAXR + 1) begin errors++;
            $display("FAIL exhaust_log: diff=%0d got_n=%0d want_n=%0d", d, log_q.size(), 3 + MAXR + 1); end
        checks++; if (cfg_error !== 1'b1 || err_count !== 8'd1) begin errors++;
            $display("FAIL exhaust_err: err=%b cnt=%0d want 1/1", cfg_error, err_count); end
    endtask

    task automatic test_timeout();
        bit ok; int bad;
        clear_plan();
        rom[0] = 24'h3008_82; rom[1] = 24'h1234_56;
        no_trend = 1'b1;
        start_run();
        wait_done(ok);
        checks++; if (!ok) begin errors++; $display("FAIL tmo_done: timeout waiting for cfg_done"); end
        checks++; if (err_count !== 8'(2 * LUT) || cfg_error !== 1'b1) begin errors++;
            $display("FAIL tmo_err: cnt=%0d err=%b want %0d/1", err_count, cfg_error, 2 * LUT); end
        bad = 0;
        foreach (len_q[i]) if (len_q[i] != 64) bad++;
        checks++; if (bad != 0 || len_q.size() != 2 * LUT * (MAXR + 1)) begin errors++;
            $display("FAIL tmo_len: bad=%0d n=%0d want n=%0d each 64 (first=%0d)", bad, len_q.size(),
                     2 * LUT * (MAXR + 1), (len_q.size() > 0) ? len_q[0] : -1); end
        no_trend = 1'b0;
    endtask

    task automatic test_delay();
        bit ok; int d;
        clear_plan();
        rom[0] = 24'h3008_82;
        rom[1] = 24'hFFFF_02;
        start_run();
        wait_done(ok);
        checks++; if (!ok) begin errors++; $display("FAIL delay_done: timeout waiting for cfg_done"); end
        d = log_diff();
        checks++; if (d != -1 || log_q.size() != 2) begin errors++;
            $display("FAIL delay_log: diff=%0d got_n=%0d want_n=2", d, log_q.size()); end
        checks++; if (gap_q.size() != 1 || gap_q[0] < 512 || gap_q[0] > 540) begin errors++;
            $display("FAIL delay_gap: n=%0d gap=%0d want 512..540", gap_q.size(),
                     (gap_q.size() > 0) ? gap_q[0] : -1); end
    endtask

    task automatic test_random();
        bit ok; int d;
        for (int it = 0; it < 4; it++) begin
            clear_plan();
            for (int e = 0; e < LUT; e++) begin
                if ($urandom_range(3, 0) == 0) rom[e] = {16'hFFFF, 8'($urandom_range(1, 0))};
                else rom[e] = {16'($urandom_range(16'hFFFE, 0)), 8'($urandom)};
            end
            for (int c = 0; c < 2; c++)
                for (int e = 0; e < LUT; e++)
                    for (int a = 0; a < 8; a++) nack_tab[c][e][a] = ($urandom_range(9, 0) < 4);
            start_run();
            wait_done(ok);
            checks++; if (!ok) begin errors++; $display("FAIL rand_done[%0d]: timeout", it); end
            d = log_diff();
            checks++; if (d != -1) begin errors++;
                $display("FAIL rand_log[%0d]: diff=%0d got_n=%0d want_n=%0d", it, d, log_q.size(), exp_q.size()); end
            checks++; if (err_count !== 8'(exp_err) || cfg_error !== (exp_err > 0)) begin errors++;
                $display("FAIL rand_err[%0d]: cnt=%0d err=%b want %0d", it, err_count, cfg_error, exp_err); end
        end
    endtask

    task automatic test_busy_ignore();
        bit ok; int d;
        clear_plan();
        rom[0] = 24'h3008_82; rom[1] = 24'h1234_56;
        start_run();
        wait_xfer(ok);
        checks++; if (!ok) begin errors++; $display("FAIL ign_xfer: no transfer started"); end
        @(negedge clock_i2c) cfg_start = 1'b1;
        @(negedge clock_i2c) cfg_start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ign_busy: got %b want 1", busy); end
        wait_done(ok);
        d = log_diff();
        checks++; if (!ok || d != -1) begin errors++;
            $display("FAIL ign_log: done=%b diff=%0d got_n=%0d want_n=%0d", ok, d, log_q.size(), exp_q.size()); end
    endtask

    task automatic test_mid_reset();
        bit ok; int d;
        clear_plan();
        rom[0] = 24'h3008_82; rom[1] = 24'h1234_56;
        no_trend = 1'b1;                     // keep the engine mid-transfer
        start_run();
        wait_xfer(ok);
        checks++; if (!ok) begin errors++; $display("FAIL mrst_xfer: no transfer started"); end
        repeat (3) @(negedge clock_i2c);
        camera_rst = 1'b1;
        @(negedge clock_i2c);
        checks++; if ({i2c_start, busy, cfg_done, cfg_error, camera1} !== 5'b0
                      || i2c_data !== 32'h0 || lut_index !== 9'h0 || err_count !== 8'h0) begin errors++;
            $display("FAIL mrst_out: start=%b busy=%b done=%b data=%h idx=%0d want all 0",
                     i2c_start, busy, cfg_done, i2c_data, lut_index); end
        camera_rst = 1'b0;
        no_trend = 1'b0;
        repeat (2) @(negedge clock_i2c);
        start_run();
        wait_done(ok);
        d = log_diff();
        checks++; if (!ok || d != -1) begin errors++;
            $display("FAIL mrst_rerun: done=%b diff=%0d got_n=%0d want_n=%0d", ok, d, log_q.size(), exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_retry();
        test_exhaust();
        test_timeout();
        test_delay();
        test_random();
        test_busy_ignore();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/camera_cfg_seq.md
CAMERA_CFG_SEQ -- requirements
Module: camera_cfg_seq

Interface
REQ-001 Parameter DEV_ADDR, default 8'h78: 8-bit I2C write address placed in i2c_data[31:24].
REQ-002 Parameter LUT_SIZE, default 256: number of configuration entries per camera, range 1..512.
REQ-003 Parameter MAX_RETRY, default 3: retries per entry after a failed transfer.
REQ-004 Parameter PWR_WAIT, default 400: clock_i2c cycles to wait after cfg_start before the first transfer.
REQ-005 Port clock_i2c, input, 1 bit: the single clock (20 kHz I2C bit clock); all logic is on its rising edge.
REQ-006 Port camera_rst, input, 1 bit: synchronous, active-high reset.
REQ-007 Port cfg_start, input, 1 bit: single-cycle pulse that starts configuration of both cameras.
REQ-008 Port lut_index, output, 9 bits: entry address to the external configuration ROM.
REQ-009 Port lut_data, input, 24 bits: {reg_addr[15:0], value[7:0]}, valid exactly one cycle after lut_index changes.
REQ-010 Port i2c_data, output, 32 bits: {DEV_ADDR, reg_addr, value} to the I2C write engine.
REQ-011 Port i2c_start, output, 1 bit: engine run level; low clears the engine's cycle counter, high runs the transfer.
REQ-012 Port tr_end, input, 1 bit: engine transfer-complete level.
REQ-013 Port ack, input, 1 bit: engine acknowledge status; 1 = NACK on at least one byte, 0 = all bytes acknowledged.
REQ-014 Port camera1, output, 1 bit: target select; 0 = camera 1 SDA, 1 = camera 2 SDA.
REQ-015 Port busy, output, 1 bit: high from acceptance of cfg_start until DONE.
REQ-016 Port cfg_done, output, 1 bit: high in DONE; held until the next accepted cfg_start or reset.
REQ-017 Port cfg_error, output, 1 bit: sticky; set when any entry exhausts its retries; cleared by an accepted cfg_start.
REQ-018 Port err_count, output, 8 bits: number of entries that failed, saturating at 255.

Function
REQ-019 States: IDLE, PWR_WAIT, LOAD, FETCH, ARM, XFER, CHECK, DELAY, NEXT, DONE.
REQ-020 IDLE/DONE + cfg_start: lut_index=0, camera1=0, err_count=0, cfg_error=0, cfg_done=0, busy=1 -> PWR_WAIT; cfg_start outside IDLE/DONE is ignored.
REQ-021 PWR_WAIT: count PWR_WAIT cycles -> LOAD.
REQ-022 LOAD: one cycle to let ROM latency elapse -> FETCH.
REQ-023 FETCH: register i2c_data = {DEV_ADDR, lut_data}; reg_addr 16'hFFFF (delay marker) -> DELAY, else -> ARM.
REQ-024 ARM: i2c_start=0 for exactly 2 cycles -> XFER.
REQ-025 XFER: i2c_start=1; i2c_data and camera1 stable; on tr_end=1 -> CHECK; no tr_end within 64 cycles counts as failure -> CHECK.
REQ-026 CHECK: i2c_start=0; if ack=0 and no timeout -> NEXT; else retry count < MAX_RETRY -> increment, ARM; else set cfg_error, increment err_count (saturating), -> NEXT.
REQ-027 DELAY: wait value*256 cycles (value 0 = no wait), no bus activity -> NEXT.
REQ-028 NEXT: clear retry count; lut_index < LUT_SIZE-1 -> increment, LOAD; else camera1=0 -> camera1=1, lut_index=0, LOAD; else -> DONE.
REQ-029 Ack is sampled only in CHECK, never during XFER.
REQ-030 Sequence length: camera 1 entries 0..LUT_SIZE-1, then camera 2 entries 0..LUT_SIZE-1; each entry is written at most MAX_RETRY+1 times.

Reset
REQ-031 camera_rst=1 at any clock edge forces IDLE: i2c_start=0, camera1=0, lut_index=0, i2c_data=0, busy=0, cfg_done=0, cfg_error=0, err_count=0, all counters 0; this applies mid-transfer too, and the engine is released by i2c_start=0.

Structure
REQ-032 Shared package camera_cfg_pkg holds the state enum, DELAY_MARKER=16'hFFFF, XFER_TIMEOUT=64, ARM_CYCLES=2.
REQ-033 A single sub-module cfg_wait_timer (load, count, expire) serves PWR_WAIT, the XFER timeout and DELAY.

Verification
REQ-034 LUT_SIZE=2, engine model always acks, cfg_start -> 4 transfers in order cam1[0], cam1[1], cam2[0], cam2[1]; i2c_data=32'h78_3008_82 for entry {3008,82}; cfg_done=1, err_count=0.
REQ-035 Engine NACKs the first 2 attempts of cam1[0] -> 3 transfers of that entry, cfg_error=0.
REQ-036 Engine NACKs every attempt of cam2[1], MAX_RETRY=3 -> 4 attempts, cfg_error=1, err_count=1, DONE still reached.
REQ-037 Engine never raises tr_end -> each attempt ends after 64 XFER cycles; err_count=2*LUT_SIZE.
REQ-038 Entry {FFFF,02} -> 512 idle cycles with i2c_start=0 and no transfer, then the next entry.
REQ-039 camera_rst pulsed in mid-XFER -> next cycle i2c_start=0, busy=0, all outputs at reset values; cfg_start pulsed while busy -> ignored.
